// File: rtl/prescaler_pow2_pkg.sv
// Shared constants and helpers for the power-of-two prescaler.
// Holds the default parameter values and the exponent saturation function.
// Pure declarations; no logic, latency or flow control of its own.
package prescaler_pkg;

  localparam int PRESC_MAX_LOG2 = 5;
  localparam int PRESC_CONF_W   = 3;

  // Clamp a requested exponent to the largest supported one.
  function automatic int unsigned sat(input int unsigned conf, input int unsigned max_log2);
    return (conf > max_log2) ? max_log2 : conf;
  endfunction

endpackage

// File: rtl/prescaler_pow2_if.sv
// Control/status bundle between a prescaler user and the prescaler.
// Carries enable and requested exponent in; divided clock, enable pulse and active exponent out.
// No handshake: en is a level that freezes the divider while low.
interface prescaler_pow2_if
  import prescaler_pkg::*;
#(
  parameter int CONF_W = PRESC_CONF_W
) ();

  logic              en;
  logic [CONF_W-1:0] conf;
  logic              clk_out;
  logic              ce;
  logic [CONF_W-1:0] conf_act;

  modport master (
    output en,
    output conf,
    input  clk_out,
    input  ce,
    input  conf_act
  );

  modport slave (
    input  en,
    input  conf,
    output clk_out,
    output ce,
    output conf_act
  );

endinterface

// File: rtl/prescaler_pow2_conf_sat.sv
// Clamps the requested division exponent to MAX_LOG2.
// Purely combinational, zero latency.
// No flow control.
module conf_sat
  import prescaler_pkg::*;
#(
  parameter int MAX_LOG2 = PRESC_MAX_LOG2,
  parameter int CONF_W   = PRESC_CONF_W
) (
  input  logic [CONF_W-1:0] conf,
  output logic [CONF_W-1:0] sat_val
);

  assign sat_val = CONF_W'(sat(32'(conf), 32'(MAX_LOG2)));

endmodule

// File: rtl/prescaler_pow2.sv
// Power-of-two clock prescaler producing a 50% square wave and a one-cycle enable pulse.
// All outputs registered; ce fires on the cycle after the counter's last value is seen.
// en low freezes counter, exponent and clk_out and forces ce low; no backpressure otherwise.
module prescaler_pow2
  import prescaler_pkg::*;
#(
  parameter int MAX_LOG2 = PRESC_MAX_LOG2,
  parameter int CONF_W   = PRESC_CONF_W
) (
  input  logic              clk,
  input  logic              rst,
  prescaler_pow2_if.slave   bus
);

  localparam logic [MAX_LOG2-1:0] CNT_ONE  = MAX_LOG2'(1);
  localparam logic [MAX_LOG2-1:0] CNT_ONES = {MAX_LOG2{1'b1}};
  localparam logic [CONF_W-1:0]   CONF_ONE = CONF_W'(1);

  logic [MAX_LOG2-1:0] cnt;
  logic [MAX_LOG2-1:0] cnt_n;
  logic [MAX_LOG2-1:0] last;
  logic [CONF_W-1:0]   conf_act;
  logic [CONF_W-1:0]   act_n;
  logic [CONF_W-1:0]   conf_clamped;
  logic                wrap;
  logic                clk_out_q;
  logic                clk_out_n;
  logic                ce_q;

  conf_sat #(
    .MAX_LOG2 (MAX_LOG2),
    .CONF_W   (CONF_W)
  ) u_conf_sat (
    .conf    (bus.conf),
    .sat_val (conf_clamped)
  );

  // Wrap detection and next counter/exponent; a new exponent is only taken at the wrap
  // so the running period always finishes at its old ratio. clk_out is derived from the
  // next state so the registered output lines up with the counter value it describes.
  always_comb begin
    last      = ~(CNT_ONES << conf_act);
    wrap      = (cnt == last);
    cnt_n     = cnt + CNT_ONE;
    act_n     = conf_act;
    clk_out_n = 1'b1;
    if (wrap) begin
      cnt_n = '0;
      act_n = conf_clamped;
    end
    // High while the counter is in the lower half of the period; any bit at or above
    // position act_n-1 being set means we are in the upper half.
    if (act_n != '0) begin
      clk_out_n = ((cnt_n & (CNT_ONES << (act_n - CONF_ONE))) == '0);
    end
  end

  // State and output registers; reset aborts the current period, en low holds everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      conf_act  <= conf_clamped;
      clk_out_q <= 1'b1;
      ce_q      <= 1'b0;
    end else if (bus.en) begin
      cnt       <= cnt_n;
      conf_act  <= act_n;
      clk_out_q <= clk_out_n;
      ce_q      <= wrap;
    end else begin
      ce_q      <= 1'b0;
    end
  end

  assign bus.clk_out  = clk_out_q;
  assign bus.ce       = ce_q;
  assign bus.conf_act = conf_act;

endmodule

// File: tb/tb_prescaler_pow2.sv
// Directed bench for prescaler_pow2 at default parameters.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Every check is an immediate assertion that counts and reports its own failure.
module tb_prescaler_pow2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  prescaler_pow2_if bus ();

  prescaler_pow2 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic expect_out(input string tag, input logic co, input logic cee, input logic [2:0] act);
    checks++;
    assert (bus.clk_out === co) else begin
      errors++;
      $error("FAIL %s clk_out observed=%b expected=%b", tag, bus.clk_out, co);
    end
    checks++;
    assert (bus.ce === cee) else begin
      errors++;
      $error("FAIL %s ce observed=%b expected=%b", tag, bus.ce, cee);
    end
    checks++;
    assert (bus.conf_act === act) else begin
      errors++;
      $error("FAIL %s conf_act observed=%0d expected=%0d", tag, bus.conf_act, act);
    end
  endtask

  initial begin
    bus.en   = 1'b0;
    bus.conf = 3'd2;

    // Reset state
    tick();
    expect_out("reset", 1'b1, 1'b0, 3'd2);

    // 1:4 divide: cnt 0,1,2,3 -> clk_out 1,1,0,0, ce on every 4th cycle
    rst = 1'b0; bus.en = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      expect_out($sformatf("div4_c%0d", i), ((i % 4) < 2), ((i % 4) == 0), 3'd2);
    end

    // 1:1: ce every enabled cycle, clk_out stuck high
    rst = 1'b1; bus.conf = 3'd0;
    tick();
    expect_out("div1_rst", 1'b1, 1'b0, 3'd0);
    rst = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      expect_out($sformatf("div1_c%0d", i), 1'b1, 1'b1, 3'd0);
    end
    bus.en = 1'b0;
    tick();
    expect_out("div1_hold", 1'b1, 1'b0, 3'd0);
    bus.en = 1'b1;

    // Over-range exponent saturates to 5: 16 high, 16 low
    rst = 1'b1; bus.conf = 3'd7;
    tick();
    expect_out("sat_rst", 1'b1, 1'b0, 3'd5);
    rst = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      tick();
      expect_out($sformatf("sat_c%0d", i), ((i % 32) < 16), (i == 32), 3'd5);
    end

    // Retarget mid-period several times; only the value present at the wrap is taken
    bus.conf = 3'd5;
    for (int i = 1; i <= 32; i++) begin
      tick();
      expect_out($sformatf("chg_c%0d", i), ((i % 32) < 16), (i == 32), (i == 32) ? 3'd1 : 3'd5);
      if (i == 10) bus.conf = 3'd1;
      if (i == 15) bus.conf = 3'd3;
      if (i == 20) bus.conf = 3'd1;
    end
    tick();
    expect_out("chg_div2_a", 1'b0, 1'b0, 3'd1);
    tick();
    expect_out("chg_div2_b", 1'b1, 1'b1, 3'd1);
    tick();
    expect_out("chg_div2_c", 1'b0, 1'b0, 3'd1);

    // Freeze at cnt=5 of a 1:8 period; resume completes in 3 enabled cycles
    rst = 1'b1; bus.conf = 3'd3;
    tick();
    expect_out("frz_rst", 1'b1, 1'b0, 3'd3);
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      expect_out($sformatf("frz_run_c%0d", i), (i < 4), 1'b0, 3'd3);
    end
    bus.en = 1'b0; bus.conf = 3'd1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      expect_out($sformatf("frz_hold_c%0d", i), 1'b0, 1'b0, 3'd3);
    end
    bus.en = 1'b1;
    tick();
    expect_out("frz_res_cnt6", 1'b0, 1'b0, 3'd3);
    tick();
    expect_out("frz_res_cnt7", 1'b0, 1'b0, 3'd3);
    tick();
    expect_out("frz_res_wrap", 1'b1, 1'b1, 3'd1);
    tick();
    expect_out("frz_res_next", 1'b0, 1'b0, 3'd1);

    // Reset pulse at cnt=6 aborts the period; first ce 8 cycles after release
    rst = 1'b1; bus.conf = 3'd3;
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      expect_out($sformatf("abort_run_c%0d", i), (i < 4), 1'b0, 3'd3);
    end
    rst = 1'b1;
    tick();
    expect_out("abort_rst", 1'b1, 1'b0, 3'd3);
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      expect_out($sformatf("abort_new_c%0d", i), ((i % 8) < 4), (i == 8), 3'd3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prescaler_pow2.md
PRESCALER_POW2 -- requirements
Module: prescaler_pow2

Interface
REQ-001 Parameter MAX_LOG2, default 5: largest supported division exponent, so the maximum ratio is 1:2^MAX_LOG2 (default 1:32).
REQ-002 Parameter CONF_W, default 3: width of conf; SHALL satisfy 2^CONF_W > MAX_LOG2.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 en  input  1  count enable; 0 freezes the divider.
REQ-006 conf  input  CONF_W  requested exponent k; ratio 1:2^k (0=1:1, 1=1:2, ... 5=1:32 at default).
REQ-007 clk_out  output  1  registered divided square wave, period 2^k clk cycles.
REQ-008 ce  output  1  registered one-cycle clock-enable pulse, once per output period.
REQ-009 conf_act  output  CONF_W  exponent currently in effect (saturated).

Function
REQ-010 Saturation: sat(conf) = conf if conf <= MAX_LOG2, else MAX_LOG2.
REQ-011 Internal counter cnt, MAX_LOG2 bits wide; last = 2^conf_act - 1.
REQ-012 Counting, en=1 and rst=0:
  - cnt == last -> cnt <= 0 and conf_act <= sat(conf).
  - otherwise -> cnt <= cnt + 1.
REQ-013 en=0: cnt, conf_act and clk_out hold; ce SHALL be 0.
REQ-014 ce <= en & (cnt == last); with conf_act=0, ce is 1 on every enabled cycle after the first.
REQ-015 clk_out, conf_act >= 1: in every cycle, clk_out = 1 iff cnt < 2^(conf_act-1); high first half, low second half, 50% duty.
REQ-016 clk_out, conf_act = 0: clk_out held at 1; consumers use ce for 1:1 operation.
REQ-017 clk_out SHALL be a flop output, computed from next-state cnt/conf_act; no combinational path from conf or en to clk_out or ce.
REQ-018 conf changes SHALL be applied only at the wrap boundary (REQ-012); the current period always completes at the old ratio, so no runt or stretched pulse is produced.
REQ-019 conf changing several times within one period: only the value present on the wrap cycle is applied.
REQ-020 en deasserted mid-period then reasserted: the period resumes from the frozen cnt and is not restarted.

Reset
REQ-021 On any clock edge with rst=1: cnt <= 0, ce <= 0, clk_out <= 1, conf_act <= sat(conf).
REQ-022 rst overrides en; asserting rst mid-period SHALL abort the period, and a new period starts at cnt=0 on the first cycle after release.

Structure
REQ-023 Package prescaler_pkg SHALL hold:
  - defaults PRESC_MAX_LOG2=5 and PRESC_CONF_W=3;
  - the sat() function, shared with conf_sat.
REQ-024 Saturation logic SHALL live in one sub-module, conf_sat, a combinational CONF_W-wide clamp to MAX_LOG2.
REQ-025 Counter, wrap detect and output flops SHALL live in prescaler_pow2; no derived clocks inside the block.

Verification
REQ-026 Defaults, rst 1->0, en=1, conf=2 -> cnt 0,1,2,3,0 repeating; clk_out 1,1,0,0 repeating; ce high on cycles 4, 8, 12 after release.
REQ-027 conf=0, en=1 -> ce=1 every cycle from cycle 1; clk_out constant 1; conf_act=0.
REQ-028 conf=5 running, change to conf=1 at cnt=10 -> current 32-cycle period completes; then period of 2 (clk_out 1,0); conf_act updates on the wrap cycle.
REQ-029 conf=7 with MAX_LOG2=5 -> conf_act=5, 32-cycle period, clk_out high 16 and low 16 cycles.
REQ-030 conf=3, en dropped for 5 cycles at cnt=5 -> cnt and clk_out frozen, ce=0; after reassertion the wrap occurs 3 enabled cycles later.
REQ-031 rst pulsed at cnt=6 with conf=3 -> next cycle cnt=0, clk_out=1, ce=0; the first ce occurs 8 cycles after release.
